// File: rtl/mem_dump_unit.sv
// mem_dump_unit
//
// Memory unloader. Acts as an initiator on the RAM's MFA/MOC port: it reads a
// contiguous run of 32-bit words starting at a word-aligned byte address and
// presents each word on a valid/ready stream, one word at a time.
//
// Ports
//   main_clk     sole clock, rising edge
//   reset        asynchronous, active-low reset
//   start        begin a dump (sampled only while idle)
//   base_addr    first byte address; low two bits ignored
//   word_count   number of words to read, 0..128
//   busy         dump in progress (request/hold phases)
//   done         one-cycle pulse at the end of every dump, aborted or not
//   err          set on a memory timeout, cleared by the next accepted start
//   mem_mfa      memory function active (request)
//   mem_rw       always 1 (read)
//   mem_size     always 2'b10 (word)
//   mem_addr     byte address of the current request
//   mem_data_in  RAM read data, valid with mem_moc
//   mem_moc      memory operation complete
//   out_valid    out_data/out_addr hold a word
//   out_data     captured word, big-endian as delivered by the RAM
//   out_addr     address of the word on out_data
//   out_ready    consumer accepts the word when out_valid is also high
module mem_dump_unit #(
    parameter int ADDR_WIDTH = 9,
    parameter int TIMEOUT    = 15
) (
    input  logic                  main_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [7:0]            word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  mem_mfa,
    output logic                  mem_rw,
    output logic [1:0]            mem_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_data_in,
    input  logic                  mem_moc,
    output logic                  out_valid,
    output logic [31:0]           out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    input  logic                  out_ready
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            remaining;
    logic [TW-1:0]         tmo_cnt;

    // The byte-offset bits of base_addr are deliberately discarded.
    logic unused_base_bits;
    assign unused_base_bits = ^base_addr[1:0];

    // Handshake outputs are pure state decodes so an asynchronous reset drops
    // them immediately and nothing combinational leaks from mem_moc/out_ready.
    assign mem_mfa   = (state == S_REQ);
    assign out_valid = (state == S_HOLD);
    assign busy      = (state == S_REQ) || (state == S_HOLD);
    assign done      = (state == S_DONE);
    assign mem_addr  = addr;
    assign mem_rw    = 1'b1;
    assign mem_size  = 2'b10;

    always_ff @(posedge main_clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            addr      <= '0;
            remaining <= '0;
            tmo_cnt   <= '0;
            err       <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        if (word_count != 8'd0) begin
                            addr      <= {base_addr[ADDR_WIDTH-1:2], 2'b00};
                            remaining <= word_count;
                            tmo_cnt   <= '0;
                            state     <= S_REQ;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_REQ: begin
                    // A completion arriving on the last allowed cycle still
                    // wins over the timeout.
                    if (mem_moc) begin
                        out_data <= mem_data_in;
                        out_addr <= addr;
                        state    <= S_HOLD;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        remaining <= remaining - 8'd1;
                        addr      <= addr + ADDR_WIDTH'(4);
                        if (remaining == 8'd1) begin
                            state <= S_DONE;
                        end else begin
                            tmo_cnt <= '0;
                            state   <= S_REQ;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_unit.sv
// tb_mem_dump_unit
//
// Directed bench for mem_dump_unit. A byte-wide RAM model (ram[i] = i mod 256)
// answers requests with a programmable number of wait cycles, and a negedge
// monitor records accepted words, busy cycles, done pulses and request starts.
module tb_mem_dump_unit;

    logic        main_clk;
    logic        reset;
    logic        start;
    logic [8:0]  base_addr;
    logic [7:0]  word_count;
    logic        busy, done, err;
    logic        mem_mfa, mem_rw;
    logic [1:0]  mem_size;
    logic [8:0]  mem_addr;
    logic [31:0] mem_data_in;
    logic        mem_moc;
    logic        out_valid;
    logic [31:0] out_data;
    logic [8:0]  out_addr;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    mem_dump_unit #(.ADDR_WIDTH(9), .TIMEOUT(15)) dut (
        .main_clk    (main_clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .word_count  (word_count),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .mem_mfa     (mem_mfa),
        .mem_rw      (mem_rw),
        .mem_size    (mem_size),
        .mem_addr    (mem_addr),
        .mem_data_in (mem_data_in),
        .mem_moc     (mem_moc),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_addr    (out_addr),
        .out_ready   (out_ready)
    );

    initial main_clk = 1'b0;
    always #5 main_clk = ~main_clk;

    // RAM model
    logic [7:0] ram [512];
    logic       moc_en;
    int         wait_n;
    int         wait_cnt;

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = i[7:0];
    end

    function automatic logic [31:0] rd_word(input logic [8:0] a);
        return {ram[a], ram[a + 9'd1], ram[a + 9'd2], ram[a + 9'd3]};
    endfunction

    always @(posedge main_clk) wait_cnt <= mem_mfa ? wait_cnt + 1 : 0;

    assign mem_moc     = mem_mfa && moc_en && (wait_cnt >= wait_n);
    assign mem_data_in = rd_word(mem_addr);

    // Monitor
    logic [31:0] wq_data [$];
    logic [8:0]  wq_addr [$];
    int          busy_cnt  = 0;
    int          done_cnt  = 0;
    int          mfa_rises = 0;
    logic        mfa_prev  = 1'b0;

    always @(negedge main_clk) begin
        if (out_valid && out_ready) begin
            wq_data.push_back(out_data);
            wq_addr.push_back(out_addr);
        end
        if (busy) busy_cnt <= busy_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (mem_mfa && !mfa_prev) mfa_rises <= mfa_rises + 1;
        mfa_prev <= mem_mfa;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge main_clk);
        #1;
    endtask

    // Returns with the DUT one cycle past the accepting edge (first REQ cycle).
    task automatic do_start(input logic [8:0] b, input logic [7:0] wc);
        start      = 1'b1;
        base_addr  = b;
        word_count = wc;
        tick;
        start = 1'b0;
    endtask

    // cyc = 1 is the first cycle after the accepting edge.
    task automatic wait_done(input int limit, output int cyc);
        cyc = 1;
        while (!done && cyc < limit) begin
            tick;
            cyc++;
        end
        check("done_seen", done, 1);
    endtask

    int nw, nb, nd, nr, cyc, spin;
    logic [31:0] d0;
    logic [8:0]  a0;

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        out_ready  = 1'b1;
        moc_en     = 1'b1;
        wait_n     = 0;
        #2 reset = 1'b0;
        tick;
        tick;

        // Reset state
        check("rst_busy",      busy,      0);
        check("rst_done",      done,      0);
        check("rst_err",       err,       0);
        check("rst_mfa",       mem_mfa,   0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_out_addr",  out_addr,  0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_mem_rw",    mem_rw,    1);
        check("rst_mem_size",  mem_size,  2);
        reset = 1'b1;
        tick;

        // Zero-wait two-word dump
        nw = wq_data.size(); nb = busy_cnt; nd = done_cnt;
        do_start(9'd0, 8'd2);
        check("zw_start_mfa",  mem_mfa, 1);
        check("zw_start_busy", busy,    1);
        wait_done(40, cyc);
        check("zw_cycles", cyc, 5);
        check("zw_done_busy", busy, 0);
        tick;
        check("zw_words", wq_data.size() - nw, 2);
        if (wq_data.size() - nw == 2) begin
            check("zw_data0", wq_data[nw],     32'h00010203);
            check("zw_addr0", wq_addr[nw],     0);
            check("zw_data1", wq_data[nw + 1], 32'h04050607);
            check("zw_addr1", wq_addr[nw + 1], 4);
        end
        check("zw_busy_cycles", busy_cnt - nb, 4);
        check("zw_done_pulses", done_cnt - nd, 1);
        check("zw_idle", done, 0);

        // Backpressure, with a start attempt while holding
        out_ready = 1'b0;
        nw = wq_data.size(); nr = mfa_rises;
        do_start(9'd8, 8'd2);
        spin = 0;
        while (!out_valid && spin < 20) begin
            tick;
            spin++;
        end
        check("bp_valid", out_valid, 1);
        d0 = out_data;
        a0 = out_addr;
        check("bp_data", d0, 32'h08090A0B);
        check("bp_addr", a0, 8);
        start      = 1'b1;
        word_count = 8'd5;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("bp_hold_data",  out_data,  32'h08090A0B);
            check("bp_hold_addr",  out_addr,  8);
            check("bp_hold_mfa",   mem_mfa,   0);
            check("bp_hold_valid", out_valid, 1);
        end
        start = 1'b0;
        check("bp_no_new_req", mfa_rises - nr, 1);
        out_ready = 1'b1;
        wait_done(40, cyc);
        tick;
        tick;
        check("bp_words", wq_data.size() - nw, 2);
        if (wq_data.size() - nw == 2) begin
            check("bp_data1", wq_data[nw + 1], 32'h0C0D0E0F);
            check("bp_addr1", wq_addr[nw + 1], 12);
        end
        check("bp_total_reqs", mfa_rises - nr, 2);
        check("bp_idle_after", busy, 0);

        // Unaligned base and wrap-around
        nw = wq_data.size();
        do_start(9'd510, 8'd2);
        check("wrap_mem_addr0", mem_addr, 508);
        tick;
        tick;
        check("wrap_mem_addr1", mem_addr, 0);
        wait_done(40, cyc);
        tick;
        check("wrap_words", wq_data.size() - nw, 2);
        if (wq_data.size() - nw == 2) begin
            check("wrap_data0", wq_data[nw],     32'hFCFDFEFF);
            check("wrap_addr0", wq_addr[nw],     508);
            check("wrap_data1", wq_data[nw + 1], 32'h00010203);
            check("wrap_addr1", wq_addr[nw + 1], 0);
        end

        // Timeout
        moc_en = 1'b0;
        do_start(9'd0, 8'd1);
        wait_done(60, cyc);
        check("tmo_cycles_after_req", cyc - 1, 16);
        check("tmo_err",  err,     1);
        check("tmo_mfa",  mem_mfa, 0);
        tick;
        check("tmo_err_held", err,  1);
        check("tmo_one_done", done, 0);
        moc_en = 1'b1;
        do_start(9'd4, 8'd1);
        check("tmo_err_cleared", err, 0);
        wait_done(40, cyc);
        tick;

        // Completion on the last allowed cycle beats the timeout
        wait_n = 15;
        nw = wq_data.size();
        do_start(9'd16, 8'd1);
        wait_done(60, cyc);
        check("tie_cycles", cyc - 1, 17);
        check("tie_err", err, 0);
        tick;
        check("tie_words", wq_data.size() - nw, 1);
        if (wq_data.size() - nw == 1) check("tie_data", wq_data[nw], 32'h10111213);
        wait_n = 0;

        // Zero-length dump
        nr = mfa_rises;
        do_start(9'd0, 8'd0);
        check("wc0_done", done,    1);
        check("wc0_mfa",  mem_mfa, 0);
        check("wc0_busy", busy,    0);
        tick;
        tick;
        check("wc0_no_req", mfa_rises - nr, 0);

        // Asynchronous reset mid-request
        moc_en = 1'b0;
        nd = done_cnt;
        do_start(9'd0, 8'd3);
        tick;
        check("ar_pre_mfa", mem_mfa, 1);
        #3 reset = 1'b0;
        #1;
        check("ar_mfa",   mem_mfa,   0);
        check("ar_busy",  busy,      0);
        check("ar_valid", out_valid, 0);
        tick;
        reset  = 1'b1;
        moc_en = 1'b1;
        tick;
        check("ar_idle_busy", busy,    0);
        check("ar_idle_mfa",  mem_mfa, 0);
        check("ar_no_done",   done_cnt - nd, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
